// File: rtl/lighthouse_pulse_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lighthouse_pulse_capture
// Description : Multi-sensor optical pulse timestamper. Each envelope input
//               is synchronised, measured (start timestamp and width),
//               classified as sync or sweep, held in a 1-deep pending slot
//               and arbitrated round-robin into a shared first-word-fall-
//               through FIFO drained through a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module lighthouse_pulse_capture #(
    parameter int NUM_SENSORS = 2,
    parameter int TS_WIDTH    = 32,
    parameter int W_BITS      = 16,
    parameter int MIN_PULSE   = 4,
    parameter int SYNC_MIN    = 2400,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SENSORS-1:0]     env_in,
    input  logic                       enable,
    output logic [TS_WIDTH-1:0]        timestamp,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [((NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1)-1:0] evt_sensor,
    output logic [TS_WIDTH-1:0]        evt_start_ts,
    output logic [W_BITS-1:0]          evt_width,
    output logic                       evt_is_sync,
    output logic [15:0]                overflow_cnt
);

    localparam int SW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(NUM_SENSORS + 1);

    localparam logic [W_BITS:0] c_min_width  = (W_BITS+1)'(MIN_PULSE);
    localparam logic [W_BITS:0] c_sync_width = (W_BITS+1)'(SYNC_MIN);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    typedef struct packed {
        logic [SW-1:0]       sensor;
        logic [TS_WIDTH-1:0] ts;
        logic [W_BITS-1:0]   width;
        logic                is_sync;
    } evt_t;

    // A saturated width always reports as sync, whatever SYNC_MIN is.
    function automatic logic f_is_sync(input logic [W_BITS-1:0] w);
        return ({1'b0, w} >= c_sync_width) || (&w);
    endfunction

    // Front end: synchroniser, edge history, arming after reset
    logic [NUM_SENSORS-1:0] sync1_q, sync1_d;
    logic [NUM_SENSORS-1:0] sync2_q, sync2_d;
    logic [NUM_SENSORS-1:0] sprev_q, sprev_d;
    logic [NUM_SENSORS-1:0] armed_q, armed_d;
    logic [1:0]             prime_q, prime_d;
    logic [TS_WIDTH-1:0]    ts_q, ts_d;

    // Channel measurement
    state_t                 state_q [NUM_SENSORS];
    state_t                 state_d [NUM_SENSORS];
    logic [TS_WIDTH-1:0]    start_q [NUM_SENSORS];
    logic [TS_WIDTH-1:0]    start_d [NUM_SENSORS];
    logic [W_BITS-1:0]      width_q [NUM_SENSORS];
    logic [W_BITS-1:0]      width_d [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] post;
    evt_t                   post_evt [NUM_SENSORS];

    // Pending slots, arbiter, overflow
    logic [NUM_SENSORS-1:0] pend_valid_q, pend_valid_d;
    evt_t                   pend_q [NUM_SENSORS];
    evt_t                   pend_d [NUM_SENSORS];
    logic [SW-1:0]          ptr_q, ptr_d;
    logic [NUM_SENSORS-1:0] grant;
    logic                   grant_any;
    logic [SW-1:0]          grant_idx;
    logic [DW-1:0]          drops;
    logic [16:0]            ovf_sum;
    logic [15:0]            ovf_q, ovf_d;

    // FIFO storage plus registered head (the head counts toward depth)
    evt_t                   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            cnt_q, cnt_d;
    logic [AW+1:0]          occupancy;
    logic                   fifo_full;
    logic                   push, pop;
    evt_t                   out_q, out_d;
    logic                   out_valid_q, out_valid_d;

    // Synchroniser, edge history, arming and channel FSMs
    always_comb begin
        sync1_d = env_in;
        sync2_d = sync1_q;
        sprev_d = sync2_q;
        ts_d    = ts_q + 1'b1;
        prime_d = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
        // A channel arms only after it has seen a genuine low once the
        // synchroniser holds real data, so a pulse already in flight at
        // reset release is never measured from the middle.
        armed_d = armed_q | ({NUM_SENSORS{prime_q == 2'd2}} & ~sync2_q);
        post    = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            state_d[i]  = state_q[i];
            start_d[i]  = start_q[i];
            width_d[i]  = width_q[i];
            post_evt[i] = '{sensor:  SW'(i),
                            ts:      start_q[i],
                            width:   width_q[i],
                            is_sync: f_is_sync(width_q[i])};
            if (!enable) begin
                state_d[i] = ST_IDLE;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (armed_q[i] && sync2_q[i] && !sprev_q[i]) begin
                            state_d[i] = ST_HIGH;
                            start_d[i] = ts_q;
                            width_d[i] = W_BITS'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (!sync2_q[i]) begin
                            state_d[i] = ST_IDLE;
                            post[i]    = ({1'b0, width_q[i]} >= c_min_width);
                        end else if (width_q[i] != '1) begin
                            width_d[i] = width_q[i] + 1'b1;
                        end
                    end
                    default: state_d[i] = ST_IDLE;
                endcase
            end
        end
    end

    // Round-robin grant of one pending slot into the FIFO
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_SENSORS) j = j - NUM_SENSORS;
            if (!grant_any && !fifo_full && pend_valid_q[j]) begin
                grant_any = 1'b1;
                grant_idx = SW'(j);
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
        if (!grant_any)                                ptr_d = ptr_q;
        else if (grant_idx == SW'(NUM_SENSORS - 1))    ptr_d = '0;
        else                                           ptr_d = grant_idx + 1'b1;
    end

    // Pending slot update and saturating drop counter
    always_comb begin
        drops = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            pend_valid_d[i] = pend_valid_q[i];
            pend_d[i]       = pend_q[i];
            if (grant[i]) pend_valid_d[i] = 1'b0;
            if (post[i]) begin
                // A slot leaving this cycle is free for the new event.
                if (!pend_valid_q[i] || grant[i]) begin
                    pend_valid_d[i] = 1'b1;
                    pend_d[i]       = post_evt[i];
                end else begin
                    drops = drops + 1'b1;
                end
            end
        end
        ovf_sum = {1'b0, ovf_q} + 17'(drops);
        ovf_d   = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end

    // FIFO pointers and registered head stage
    always_comb begin
        occupancy   = {1'b0, cnt_q} + (AW+2)'(out_valid_q);
        fifo_full   = occupancy >= (AW+2)'(FIFO_DEPTH);
        push        = grant_any;
        pop         = (cnt_q != '0) && (!out_valid_q || evt_ready);
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (pop) begin
            out_d       = mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
        end else if (evt_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sprev_q      <= '0;
            armed_q      <= '0;
            prime_q      <= '0;
            ts_q         <= '0;
            pend_valid_q <= '0;
            ptr_q        <= '0;
            ovf_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                state_q[i] <= ST_IDLE;
                start_q[i] <= '0;
                width_q[i] <= '0;
                pend_q[i]  <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sprev_q      <= sprev_d;
            armed_q      <= armed_d;
            prime_q      <= prime_d;
            ts_q         <= ts_d;
            pend_valid_q <= pend_valid_d;
            ptr_q        <= ptr_d;
            ovf_q        <= ovf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                state_q[i] <= state_d[i];
                start_q[i] <= start_d[i];
                width_q[i] <= width_d[i];
                pend_q[i]  <= pend_d[i];
            end
        end
    end

    // FIFO storage; contents are qualified by the pointers so need no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= pend_q[grant_idx];
    end

    assign timestamp    = ts_q;
    assign evt_valid    = out_valid_q;
    assign evt_sensor   = out_q.sensor;
    assign evt_start_ts = out_q.ts;
    assign evt_width    = out_q.width;
    assign evt_is_sync  = out_q.is_sync;
    assign overflow_cnt = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_lighthouse_pulse_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lighthouse_pulse_capture
// Description : Self-checking bench: table of single pulses plus hand-written
//               sequences; expected events queued at stimulus time and
//               compared as the DUT delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lighthouse_pulse_capture;

    localparam int NS  = 2;
    localparam int TSW = 32;
    localparam int WB  = 16;
    localparam int SW  = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [NS-1:0]  env_in;
    logic           enable;
    logic [TSW-1:0] timestamp;
    logic           evt_valid;
    logic           evt_ready;
    logic [SW-1:0]  evt_sensor;
    logic [TSW-1:0] evt_start_ts;
    logic [WB-1:0]  evt_width;
    logic           evt_is_sync;
    logic [15:0]    overflow_cnt;

    lighthouse_pulse_capture #(
        .NUM_SENSORS(NS), .TS_WIDTH(TSW), .W_BITS(WB),
        .MIN_PULSE(4), .SYNC_MIN(2400), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .env_in(env_in), .enable(enable),
        .timestamp(timestamp), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_sensor(evt_sensor), .evt_start_ts(evt_start_ts),
        .evt_width(evt_width), .evt_is_sync(evt_is_sync),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    // Reference free-running timestamp
    logic [TSW-1:0] tb_ts;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 1'b1;
    end

    typedef struct packed {
        logic [SW-1:0]  sensor;
        logic [TSW-1:0] ts;
        logic [WB-1:0]  width;
        logic           is_sync;
    } ev_t;

    typedef struct {
        int sensor;
        int width;
        bit emit;
        bit sync;
    } vec_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare delivered events, and hold stability under back-pressure
    ev_t got, prev;
    bit  held = 1'b0;
    always @(negedge clk) begin
        got = {evt_sensor, evt_start_ts, evt_width, evt_is_sync};
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held && evt_valid) check("hold_stable", got, prev);
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got sensor %0d width %0d ts %0d, expected none",
                             evt_sensor, evt_width, evt_start_ts);
                end else begin
                    check("event", got, exp_q.pop_front());
                end
            end
            held = evt_valid && !evt_ready;
            prev = got;
        end
    end

    // One pulse of w raw cycles; s rises two cycles after the raw rise
    task automatic pulse(input int sn, input int w, input bit emit, input bit sync, input int gap);
        @(posedge clk); #1;
        env_in[sn] = 1'b1;
        if (emit) exp_q.push_back({SW'(sn), tb_ts + 32'd2, 16'(w), sync});
        repeat (w) begin @(posedge clk); #1; end
        env_in[sn] = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   lat;

        vecs[0] = '{sensor: 0, width: 100,  emit: 1'b1, sync: 1'b0};
        vecs[1] = '{sensor: 1, width: 3000, emit: 1'b1, sync: 1'b1};
        vecs[2] = '{sensor: 0, width: 2399, emit: 1'b1, sync: 1'b0};
        vecs[3] = '{sensor: 1, width: 2400, emit: 1'b1, sync: 1'b1};
        vecs[4] = '{sensor: 0, width: 3,    emit: 1'b0, sync: 1'b0};
        vecs[5] = '{sensor: 1, width: 3,    emit: 1'b0, sync: 1'b0};
        vecs[6] = '{sensor: 0, width: 4,    emit: 1'b1, sync: 1'b0};
        vecs[7] = '{sensor: 1, width: 4,    emit: 1'b1, sync: 1'b0};

        rst       = 1'b1;
        env_in    = '0;
        enable    = 1'b1;
        evt_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",    evt_valid,    0);
        check("rst_sensor",   evt_sensor,   0);
        check("rst_start_ts", evt_start_ts, 0);
        check("rst_width",    evt_width,    0);
        check("rst_sync",     evt_is_sync,  0);
        check("rst_overflow", overflow_cnt, 0);
        check("rst_timestamp", timestamp,   0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("timestamp", timestamp, tb_ts);

        // Single pulses: widths, classification, glitch filter
        for (int i = 0; i < 8; i++) begin
            pulse(vecs[i].sensor, vecs[i].width, vecs[i].emit, vecs[i].sync, 8);
            wait_drain($sformatf("vec%0d_drain", i));
        end
        @(negedge clk);
        check("filter_overflow", overflow_cnt, 0);

        // Event latency: valid five cycles after the raw fall
        @(posedge clk); #1;
        env_in[1] = 1'b1;
        exp_q.push_back({1'b1, tb_ts + 32'd2, 16'd10, 1'b0});
        repeat (10) begin @(posedge clk); #1; end
        env_in[1] = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (evt_valid) break;
        end
        check("event_latency", lat - 1, 5);
        wait_drain("latency_drain");

        // Simultaneous falls after reset: sensor 0 first, then sensor 1
        do_reset();
        @(posedge clk); #1;
        env_in = 2'b11;
        exp_q.push_back({1'b0, tb_ts + 32'd2, 16'd20, 1'b0});
        exp_q.push_back({1'b1, tb_ts + 32'd2, 16'd20, 1'b0});
        repeat (20) begin @(posedge clk); #1; end
        env_in = 2'b00;
        wait_drain("simul_drain");

        // Back-pressure: 8 in FIFO, 1 pending, 1 dropped
        @(posedge clk); #1 evt_ready = 1'b0;
        for (int i = 0; i < 10; i++) pulse(0, 6 + i, (i < 9), 1'b0, 6);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_overflow", overflow_cnt, 1);
        check("bp_valid",    evt_valid,    1);
        @(posedge clk); #1 evt_ready = 1'b1;
        wait_drain("bp_drain");
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_empty", evt_valid, 0);

        // Reset in the middle of a pulse, released while still high
        @(posedge clk); #1 env_in[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_valid",     evt_valid,    0);
        check("midrst_overflow",  overflow_cnt, 0);
        check("midrst_width",     evt_width,    0);
        check("midrst_timestamp", timestamp,    0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        env_in[0] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midrst_no_event", evt_valid, 0);
        pulse(0, 10, 1'b1, 1'b0, 8);
        wait_drain("midrst_next_pulse");

        // Enable dropped mid-pulse, restored while still high
        @(posedge clk); #1 env_in[1] = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        enable = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        enable = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        env_in[1] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("enable_discard", evt_valid, 0);
        pulse(1, 12, 1'b1, 1'b0, 8);
        wait_drain("enable_next_pulse");
        @(negedge clk);
        check("final_overflow", overflow_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
